// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared BCD types and conversion helpers for the time field counters
package stopwatch_pkg;
   localparam int BCD_W = 4;
   typedef logic [3:0] bcd_digit_t;
   function automatic int bcd_to_bin(input logic [15:0] bcd, input int digits);
      int v;
      v = 0;
      for (int i = 3; i >= 0; i--)
         if (i < digits) v = v * 10 + int'(bcd[i*BCD_W +: BCD_W]);
      return v;
   endfunction
   function automatic logic bcd_valid(input logic [15:0] bcd, input int digits);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++)
         if (i < digits && bcd[i*BCD_W +: BCD_W] > 4'd9) ok = 1'b0;
      return ok;
   endfunction
   function automatic logic [15:0] bin_to_bcd(input int val);
      logic [15:0] r;
      int v;
      v = val;
      for (int i = 0; i < 4; i++) begin
         r[i*BCD_W +: BCD_W] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction
endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one BCD digit of the ripple increment/decrement chain
module bcd_digit_step
   import stopwatch_pkg::*;
(
   input  bcd_digit_t digit_i,
   input  logic       up_i,
   input  logic       carry_i,
   output bcd_digit_t digit_o,
   output logic       carry_o
);
   logic edge_digit;
   always_comb begin
      edge_digit = up_i ? (digit_i == 4'd9) : (digit_i == 4'd0);
      carry_o = carry_i & edge_digit;
      digit_o = !carry_i ? digit_i :
                up_i     ? (edge_digit ? 4'd0 : digit_i + 4'd1) :
                           (edge_digit ? 4'd9 : digit_i - 4'd1);
   end
endmodule

// File: rtl/bcd_field_counter.sv
// bcd_field_counter: cascadable packed-BCD time field counter with up/down, clear, load and hold
module bcd_field_counter
   import stopwatch_pkg::*;
#(
   parameter int DIGITS  = 2,
   parameter int MAX_VAL = 59
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick_i,
   input  logic                  up_i,
   input  logic                  hold_i,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [BCD_W*DIGITS-1:0] load_bcd_i,
   output logic [BCD_W*DIGITS-1:0] count_bcd_o,
   output logic                  carry_o,
   output logic                  at_max_o,
   output logic                  load_err_o
);
   localparam int W = BCD_W * DIGITS;
   localparam logic [15:0] MAX16 = bin_to_bcd(MAX_VAL);
   localparam logic [W-1:0] MAX_BCD = MAX16[W-1:0];
   if (DIGITS < 1 || DIGITS > 4 || MAX_VAL < 1 || MAX_VAL >= 10**DIGITS) begin : g_bad_param
      $error("bcd_field_counter: MAX_VAL out of range for DIGITS");
   end
   logic [W-1:0] count_q, count_d, step_bcd;
   logic [DIGITS:0] c;
   logic carry_q, carry_d, at_max_q, at_max_d, err_q, err_d;
   logic tick, wrap, load_ok;
   assign c[0] = 1'b1;
   for (genvar i = 0; i < DIGITS; i++) begin : g_step
      bcd_digit_step u_step (
         .digit_i (count_q[i*BCD_W +: BCD_W]),
         .up_i    (up_i),
         .carry_i (c[i]),
         .digit_o (step_bcd[i*BCD_W +: BCD_W]),
         .carry_o (c[i+1])
      );
   end
   // borrow out of the top digit means every digit was 0
   always_comb begin
      tick     = tick_i & ~hold_i;
      wrap     = up_i ? (count_q == MAX_BCD) : c[DIGITS];
      load_ok  = bcd_valid(16'(load_bcd_i), DIGITS) && bcd_to_bin(16'(load_bcd_i), DIGITS) <= MAX_VAL;
      count_d  = clear_i ? '0 :
                 load_i  ? (load_ok ? load_bcd_i : count_q) :
                 tick    ? (wrap ? (up_i ? '0 : MAX_BCD) : step_bcd) :
                           count_q;
      carry_d  = ~clear_i & ~load_i & tick & wrap;
      err_d    = ~clear_i & load_i & ~load_ok;
      at_max_d = count_d == MAX_BCD;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         carry_q  <= 1'b0;
         at_max_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         carry_q  <= carry_d;
         at_max_q <= at_max_d;
         err_q    <= err_d;
      end
   end
   assign count_bcd_o = count_q;
   assign carry_o     = carry_q;
   assign at_max_o    = at_max_q;
   assign load_err_o  = err_q;
endmodule

// File: tb/tb_bcd_field_counter.sv
// tb_bcd_field_counter: directed checks of seconds/minutes cascade and an hours field
module tb_bcd_field_counter;
   logic clk = 1'b0, rst_n = 1'b0;
   logic tick = 1'b0, up = 1'b1, hold = 1'b0, clear = 1'b0;
   logic load_a = 1'b0, load_b = 1'b0, load_h = 1'b0, tick_h = 1'b0;
   logic [7:0] lbcd = 8'h00;
   logic [7:0] count_a, count_b, count_h;
   logic carry_a, carry_b, carry_h, max_a, max_b, max_h, err_a, err_b, err_h;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   bcd_field_counter #(.DIGITS(2), .MAX_VAL(59)) u_a (
      .clk(clk), .rst_n(rst_n), .tick_i(tick), .up_i(up), .hold_i(hold), .clear_i(clear),
      .load_i(load_a), .load_bcd_i(lbcd), .count_bcd_o(count_a), .carry_o(carry_a),
      .at_max_o(max_a), .load_err_o(err_a));
   bcd_field_counter #(.DIGITS(2), .MAX_VAL(59)) u_b (
      .clk(clk), .rst_n(rst_n), .tick_i(carry_a), .up_i(1'b1), .hold_i(1'b0), .clear_i(clear),
      .load_i(load_b), .load_bcd_i(lbcd), .count_bcd_o(count_b), .carry_o(carry_b),
      .at_max_o(max_b), .load_err_o(err_b));
   bcd_field_counter #(.DIGITS(2), .MAX_VAL(23)) u_h (
      .clk(clk), .rst_n(rst_n), .tick_i(tick_h), .up_i(up), .hold_i(1'b0), .clear_i(1'b0),
      .load_i(load_h), .load_bcd_i(lbcd), .count_bcd_o(count_h), .carry_o(carry_h),
      .at_max_o(max_h), .load_err_o(err_h));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   always @(negedge clk) if (rst_n) begin
      assert (count_a[3:0] <= 4'd9 && count_a[7:4] <= 4'd5) else $error("count_a out of range %h", count_a);
      assert (count_b[3:0] <= 4'd9 && count_b[7:4] <= 4'd5) else $error("count_b out of range %h", count_b);
      assert (count_h[3:0] <= 4'd9 && (count_h[7:4] < 4'd2 || (count_h[7:4] == 4'd2 && count_h[3:0] <= 4'd3)))
         else $error("count_h out of range %h", count_h);
   end

   initial begin
      #1;
      chk("rst_count", 32'(count_a), 32'h0);
      step();
      step();
      chk("rst_carry", 32'(carry_a), 32'h0);
      chk("rst_max", 32'(max_a), 32'h0);
      chk("rst_err", 32'(err_a), 32'h0);
      chk("rst_count_h", 32'(count_h), 32'h0);
      rst_n = 1'b1;
      // 60 up-ticks: full lap with one carry on the wrap
      tick = 1'b1;
      up = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         step();
         chk("up_count", 32'(count_a), 32'(to_bcd(i % 60)));
         chk("up_carry", 32'(carry_a), 32'(i == 60));
         chk("up_max", 32'(max_a), 32'(i == 59));
      end
      tick = 1'b0;
      step();
      chk("up_carry_end", 32'(carry_a), 32'h0);
      chk("cascade_b1", 32'(count_b), 32'h01);
      // down-wrap from zero
      load_a = 1'b1; lbcd = 8'h00;
      step();
      load_a = 1'b0;
      chk("ld00", 32'(count_a), 32'h00);
      tick = 1'b1; up = 1'b0;
      step();
      chk("dn_wrap", 32'(count_a), 32'h59);
      chk("dn_wrap_carry", 32'(carry_a), 32'h1);
      chk("dn_wrap_max", 32'(max_a), 32'h1);
      step();
      tick = 1'b0;
      chk("dn_58", 32'(count_a), 32'h58);
      chk("dn_58_carry", 32'(carry_a), 32'h0);
      chk("dn_58_max", 32'(max_a), 32'h0);
      // hours field: digit rollover and wrap at 23
      up = 1'b1;
      load_h = 1'b1; lbcd = 8'h19;
      step();
      load_h = 1'b0; tick_h = 1'b1;
      chk("h_ld19", 32'(count_h), 32'h19);
      step();
      tick_h = 1'b0;
      chk("h_20", 32'(count_h), 32'h20);
      chk("h_20_carry", 32'(carry_h), 32'h0);
      load_h = 1'b1; lbcd = 8'h23;
      step();
      load_h = 1'b0; tick_h = 1'b1;
      chk("h_ld23", 32'(count_h), 32'h23);
      chk("h_max", 32'(max_h), 32'h1);
      step();
      tick_h = 1'b0;
      chk("h_wrap", 32'(count_h), 32'h00);
      chk("h_wrap_carry", 32'(carry_h), 32'h1);
      step();
      chk("h_carry_pulse", 32'(carry_h), 32'h0);
      load_h = 1'b1; lbcd = 8'h24;
      step();
      load_h = 1'b0;
      chk("h_bad24_err", 32'(err_h), 32'h1);
      chk("h_bad24_cnt", 32'(count_h), 32'h00);
      // invalid loads with a tick on the same edge
      load_a = 1'b1; lbcd = 8'h60; tick = 1'b1;
      step();
      load_a = 1'b0; tick = 1'b0;
      chk("bad60_cnt", 32'(count_a), 32'h58);
      chk("bad60_err", 32'(err_a), 32'h1);
      chk("bad60_carry", 32'(carry_a), 32'h0);
      step();
      chk("bad60_pulse", 32'(err_a), 32'h0);
      load_a = 1'b1; lbcd = 8'h3A; tick = 1'b1;
      step();
      load_a = 1'b0; tick = 1'b0;
      chk("bad3A_cnt", 32'(count_a), 32'h58);
      chk("bad3A_err", 32'(err_a), 32'h1);
      step();
      chk("bad3A_pulse", 32'(err_a), 32'h0);
      chk("bad3A_hold", 32'(count_a), 32'h58);
      load_a = 1'b1; lbcd = 8'h59;
      step();
      load_a = 1'b0;
      chk("ld59_cnt", 32'(count_a), 32'h59);
      chk("ld59_max", 32'(max_a), 32'h1);
      chk("ld59_err", 32'(err_a), 32'h0);
      // priority: clear beats load and tick
      load_a = 1'b1; lbcd = 8'h30;
      step();
      chk("ld30", 32'(count_a), 32'h30);
      clear = 1'b1; load_a = 1'b1; lbcd = 8'h45; tick = 1'b1;
      step();
      clear = 1'b0; load_a = 1'b0;
      chk("clr_cnt", 32'(count_a), 32'h00);
      chk("clr_err", 32'(err_a), 32'h0);
      chk("clr_carry", 32'(carry_a), 32'h0);
      hold = 1'b1;
      repeat (5) step();
      chk("hold_cnt", 32'(count_a), 32'h00);
      chk("hold_carry", 32'(carry_a), 32'h0);
      load_a = 1'b1; lbcd = 8'h42;
      step();
      load_a = 1'b0; hold = 1'b0; tick = 1'b0;
      chk("hold_ld", 32'(count_a), 32'h42);
      // cascade: 59:59 -> 00:00 with staggered carries
      clear = 1'b1;
      step();
      clear = 1'b0;
      load_a = 1'b1; load_b = 1'b1; lbcd = 8'h59;
      step();
      load_a = 1'b0; load_b = 1'b0;
      chk("cas_a59", 32'(count_a), 32'h59);
      chk("cas_b59", 32'(count_b), 32'h59);
      tick = 1'b1; up = 1'b1;
      step();
      tick = 1'b0;
      chk("cas_a0", 32'(count_a), 32'h00);
      chk("cas_a_carry", 32'(carry_a), 32'h1);
      chk("cas_b_still", 32'(count_b), 32'h59);
      chk("cas_b_nocarry", 32'(carry_b), 32'h0);
      step();
      chk("cas_b0", 32'(count_b), 32'h00);
      chk("cas_b_carry", 32'(carry_b), 32'h1);
      chk("cas_a_carry_off", 32'(carry_a), 32'h0);
      // async reset in the middle of a carry pulse
      load_a = 1'b1; load_b = 1'b1; lbcd = 8'h59;
      step();
      load_a = 1'b0; load_b = 1'b0; tick = 1'b1;
      step();
      tick = 1'b0;
      chk("mid_carry_pre", 32'(carry_a), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_carry_a", 32'(carry_a), 32'h0);
      chk("async_count_a", 32'(count_a), 32'h0);
      chk("async_max_b", 32'(max_b), 32'h0);
      chk("async_count_b", 32'(count_b), 32'h0);
      chk("async_err_b", 32'(err_b), 32'h0);
      step();
      rst_n = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bcd_field_counter.md
Name: bcd_field_counter

Overview:
- Generalised stopwatch/clock field counter: holds one time field (seconds, minutes, hours, hundredths) as DIGITS packed BCD digits.
- Counts from 0 to MAX_VAL on a tick enable, either up or down, and wraps at both ends.
- Fields cascade: one stage's carry_o drives the next stage's tick_i.
- Adds to the single-digit counter: direction control, clear, validated BCD load, hold, borrow, and an explicit active-low reset.

Parameters:
- DIGITS, 2, number of BCD digits in the field (1..4).
- MAX_VAL, 59, terminal value in decimal. Elaboration error if MAX_VAL >= 10**DIGITS or MAX_VAL < 1.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick_i  in  1  count enable, one-cycle pulse (level also accepted; counts every cycle it is high).
- up_i  in  1  1 = count up, 0 = count down; sampled with tick_i.
- hold_i  in  1  freezes counting; tick_i ignored while high.
- clear_i  in  1  synchronous clear to 0.
- load_i  in  1  synchronous load request.
- load_bcd_i  in  4*DIGITS  packed BCD load value; digit 0 in [3:0].
- count_bcd_o  out  4*DIGITS  current value, packed BCD, registered.
- carry_o  out  1  one-cycle pulse: up-wrap MAX_VAL->0 or down-wrap 0->MAX_VAL.
- at_max_o  out  1  registered; high when count == MAX_VAL.
- load_err_o  out  1  one-cycle pulse: rejected load.

Behaviour:
- Reset (rst_n low, async): count_bcd_o = 0, carry_o = 0, at_max_o = 0, load_err_o = 0. Counting resumes on the first edge after deassertion.
- Per-edge priority: clear_i > load_i > (tick_i & ~hold_i) > idle.
- clear_i:
  - count -> 0; carry_o = 0.
  - A simultaneous load or tick is discarded, with no load_err_o.
- load_i:
  - Valid load: every digit <= 9 and decimal value <= MAX_VAL. Count <= load value, carry_o = 0.
  - Invalid load: count unchanged, load_err_o = 1 next cycle, carry_o = 0.
  - A simultaneous tick is always discarded, whether the load is valid or not.
- Tick, up (up_i = 1):
  - count == MAX_VAL: count -> 0, carry_o = 1.
  - Otherwise: BCD increment, where a digit at 9 rolls to 0 and increments the next digit. carry_o = 0.
- Tick, down (up_i = 0):
  - count == 0: count -> MAX_VAL, carry_o = 1.
  - Otherwise: BCD decrement, where a digit at 0 rolls to 9 and borrows from the next digit. carry_o = 0.
- Latency:
  - count_bcd_o and carry_o update on the same edge that samples tick_i, so carry_o is coincident with the wrapped count.
  - Each cascaded stage adds 1 cycle of latency from its tick_i to its carry_o.
- Output pulses: carry_o and load_err_o are high for exactly one cycle per event, never held.
- at_max_o: recomputed from the next-state count, so it is valid on the same cycle as count_bcd_o.
- hold_i: blocks only ticks; clear_i and load_i still act.
- Reset mid-operation: a pending carry_o or load_err_o pulse is cancelled immediately and asynchronously.
- The count never leaves the range 0..MAX_VAL and never holds a non-BCD digit. Assertion required in the bench.

Decomposition:
- Shared package stopwatch_pkg:
  - constant BCD_W = 4;
  - typedef bcd_digit_t = logic [3:0];
  - function bcd_to_bin (packed BCD to integer), used for load validation and the MAX_VAL compare;
  - function bin_to_bcd, used to build the MAX_VAL constant.
- Sub-module bcd_digit_step (combinational):
  - inputs: one digit, up, carry_in.
  - outputs: next digit, carry_out.
  - Instantiated DIGITS times as the ripple chain.
  - The top level handles the wrap to 0 / MAX_VAL and priority; bcd_digit_step does neither.

Test Plan:
1. Reset then 60 up-ticks, defaults (DIGITS=2, MAX_VAL=59) -> count 00..59 then 00; carry_o pulses exactly once, on the 60th tick; at_max_o high only while count = 59.
2. Load 0x00, then 1 down-tick -> count 0x59, carry_o = 1 for one cycle. One further down-tick -> 0x58, carry_o = 0.
3. Digit rollover with MAX_VAL=23 (hours): load 0x19, up-tick -> 0x20. Load 0x23, up-tick -> 0x00 with carry_o.
4. Invalid loads 0x60 and 0x3A, each with tick_i high -> count unchanged, load_err_o one-cycle pulse for each, no tick applied.
5. Priority check at count 0x30: clear_i + load_i(0x45) + tick_i on the same edge -> 0x00, no load_err_o. Then hold_i = 1 with 5 ticks -> stays 0x00. Load with hold_i = 1 -> load applies.
6. Two cascaded instances (59 feeding 59): from 59:59, one up-tick -> first stage 00 plus carry, next cycle second stage 00 plus carry. Assert rst_n low mid-pulse -> all outputs 0 without waiting for a clock edge.
